// File: rtl/acc_pkg.sv
// -----------------------------------------------------------------------------
// acc_pkg
//   Shared definitions for sample_accumulator and the Suma wrappers built on it.
//
//   Contents:
//     state_e        FSM state encoding (IDLE, ACC, DONE)
//     sample_width() sample width in bits for a given MSB index
//     sum_width()    window-total width that holds SAMPLES*OSF worst-case samples
//     cnt_width()    modulo-N window counter width (never below 1 bit)
// -----------------------------------------------------------------------------
package acc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Samples are two's complement with MSB index 'size'.
  function automatic int sample_width(input int size);
    return size + 1;
  endfunction

  // N samples of -2^size sum to -N*2^size.  That value fits exactly in
  // $clog2(N) extra bits above the sample width, so the total never overflows.
  function automatic int sum_width(input int samples, input int osf, input int size);
    return $clog2(samples * osf) + size + 1;
  endfunction

  // A window of one sample still needs a 1-bit counter to exist.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage : acc_pkg

// File: rtl/acc_window_counter.sv
// -----------------------------------------------------------------------------
// acc_window_counter
//   Modulo-N sample counter for one accumulation window.  Counts enabled
//   cycles from 0 to N-1 and wraps to 0 on the enabled cycle at N-1.
//
//   Parameters:
//     N      window length in samples
//     W      counter width (defaults to cnt_width(N))
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset, count -> 0
//     clear  synchronous clear to 0 (wins over en)
//     en     count one sample this cycle
//     tc     terminal count: counter currently holds N-1
// -----------------------------------------------------------------------------
module acc_window_counter
  import acc_pkg::*;
#(
  parameter int N = 8,
  parameter int W = cnt_width(N)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic en,
  output logic tc
);

  logic [W-1:0] count;

  assign tc = (count == W'(N - 1));

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of the order the always blocks are evaluated.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en) begin
      // Explicit wrap keeps non-power-of-two windows correct.
      count <= tc ? '0 : count + W'(1);
    end
  end

endmodule : acc_window_counter

// File: rtl/sample_accumulator.sv
// -----------------------------------------------------------------------------
// sample_accumulator
//   Windowed accumulator: after START, sums exactly N = SAMPLES*OSF signed
//   samples (one per IN_VALID cycle) and presents the total on OUT_DATA with a
//   one-cycle OUT_VALID strobe.  Two instances typically feed Suma.Input1/2;
//   OUT_DATA is already at the Suma input width.
//
//   Build option:
//     ACC_CLEAR_EN   adds input CLEAR: synchronous abort to IDLE from any
//                    state, highest priority; OUT_DATA is left untouched.
//
//   Parameters:
//     SAMPLES   samples per symbol window
//     OSF       oversampling factor
//     SIZE      sample MSB index (samples are SIZE+1 bits, two's complement)
//   Ports:
//     CLK        rising-edge clock
//     RST_N      asynchronous active-low reset
//     CLEAR      (ACC_CLEAR_EN only) abort current window
//     START      begin a window; honoured only in IDLE
//     IN_VALID   IN_DATA carries a sample this cycle; honoured only in ACC
//     IN_DATA    signed sample
//     OUT_VALID  one-cycle strobe, OUT_DATA holds a new total
//     OUT_DATA   signed window total, held until the next window completes
//     BUSY       high while in ACC or DONE
// -----------------------------------------------------------------------------
module sample_accumulator
  import acc_pkg::*;
#(
  parameter int SAMPLES = 128,
  parameter int OSF     = 8,
  parameter int SIZE    = 11
) (
  input  logic                                         CLK,
  input  logic                                         RST_N,
`ifdef ACC_CLEAR_EN
  input  logic                                         CLEAR,
`endif
  input  logic                                         START,
  input  logic                                         IN_VALID,
  input  logic signed [sample_width(SIZE)-1:0]         IN_DATA,
  output logic                                         OUT_VALID,
  output logic signed [sum_width(SAMPLES,OSF,SIZE)-1:0] OUT_DATA,
  output logic                                         BUSY
);

  localparam int N        = SAMPLES * OSF;
  localparam int SAMPLE_W = sample_width(SIZE);
  localparam int SUM_W    = sum_width(SAMPLES, OSF, SIZE);
  localparam int CNT_W    = cnt_width(N);

  state_e                   state;
  state_e                   state_next;
  logic signed [SUM_W-1:0]  acc;
  logic signed [SUM_W-1:0]  sample_ext;
  logic signed [SUM_W-1:0]  acc_sum;
  logic                     clear_req;
  logic                     cnt_clear;
  logic                     cnt_en;
  logic                     cnt_tc;
  logic                     last_sample;

`ifdef ACC_CLEAR_EN
  assign clear_req = CLEAR;
`else
  assign clear_req = 1'b0;
`endif

  // Sign-extend the sample to the accumulator width before adding.
  assign sample_ext  = {{(SUM_W - SAMPLE_W){IN_DATA[SIZE]}}, IN_DATA};
  assign acc_sum     = acc + sample_ext;
  assign last_sample = cnt_en && cnt_tc;

  acc_window_counter #(
    .N (N),
    .W (CNT_W)
  ) u_window_counter (
    .clk   (CLK),
    .rst_n (RST_N),
    .clear (cnt_clear),
    .en    (cnt_en),
    .tc    (cnt_tc)
  );

  // Next-state and counter control.  START is only looked at in IDLE and
  // IN_VALID only in ACC, so stray strobes elsewhere are dropped.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no path through
    // this block leaves a value unassigned and infers a latch.
    state_next = state;
    cnt_clear  = 1'b0;
    cnt_en     = 1'b0;

    if (clear_req) begin
      state_next = ST_IDLE;
      cnt_clear  = 1'b1;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (START) begin
            state_next = ST_ACC;
            cnt_clear  = 1'b1;
          end
        end
        ST_ACC: begin
          if (IN_VALID) begin
            cnt_en = 1'b1;
            if (cnt_tc) begin
              state_next = ST_DONE;
            end
          end
        end
        ST_DONE: begin
          state_next = ST_IDLE;
        end
        default: begin
          state_next = ST_IDLE;
        end
      endcase
    end
  end

  // State, datapath and registered outputs.  OUT_DATA is loaded on the edge
  // that accepts the final sample, so it is valid together with OUT_VALID
  // during the DONE cycle.  BUSY is registered from the next state so it
  // tracks ACC/DONE exactly.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= ST_IDLE;
      acc       <= '0;
      OUT_VALID <= 1'b0;
      OUT_DATA  <= '0;
      BUSY      <= 1'b0;
    end else begin
      state     <= state_next;
      BUSY      <= (state_next != ST_IDLE);
      OUT_VALID <= 1'b0;

      if (cnt_clear) begin
        acc <= '0;
      end else if (cnt_en) begin
        acc <= acc_sum;
      end

      if (last_sample) begin
        OUT_DATA  <= acc_sum;
        OUT_VALID <= 1'b1;
      end
    end
  end

endmodule : sample_accumulator

// File: tb/tb_sample_accumulator.sv
// -----------------------------------------------------------------------------
// tb_sample_accumulator
//   Self-checking bench for sample_accumulator with SAMPLES=4, OSF=2, SIZE=3
//   (N=8, 4-bit samples, 7-bit total).  A cycle-by-cycle vector table covers
//   idle behaviour, a full window, ignored START/IN_VALID; hand-written
//   sequences cover IN_VALID gaps, reset mid-window and (with ACC_CLEAR_EN)
//   the CLEAR abort.
// -----------------------------------------------------------------------------
module tb_sample_accumulator;

  localparam int SAMPLES = 4;
  localparam int OSF     = 2;
  localparam int SIZE    = 3;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic              in_valid;
  logic signed [3:0] in_data;
  logic              out_valid;
  logic signed [6:0] out_data;
  logic              busy;
`ifdef ACC_CLEAR_EN
  logic              clear;
`endif

  int n_checks;
  int n_errors;

  sample_accumulator #(
    .SAMPLES (SAMPLES),
    .OSF     (OSF),
    .SIZE    (SIZE)
  ) dut (
    .CLK       (clk),
    .RST_N     (rst_n),
`ifdef ACC_CLEAR_EN
    .CLEAR     (clear),
`endif
    .START     (start),
    .IN_VALID  (in_valid),
    .IN_DATA   (in_data),
    .OUT_VALID (out_valid),
    .OUT_DATA  (out_data),
    .BUSY      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic start;
    logic in_valid;
    int   in_data;
    logic exp_valid;
    int   exp_data;
    logic exp_busy;
  } vec_t;

  localparam int NVEC = 26;
  vec_t vecs [NVEC];

  function automatic vec_t mk(input logic s, input logic v, input int d,
                              input logic ev, input int ed, input logic eb);
    vec_t r;
    r.start     = s;
    r.in_valid  = v;
    r.in_data   = d;
    r.exp_valid = ev;
    r.exp_data  = ed;
    r.exp_busy  = eb;
    return r;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_outs(input string tag, input logic ev, input int ed, input logic eb);
    check({tag, " out_valid"}, int'(out_valid), int'(ev));
    check({tag, " out_data"}, int'(out_data), ed);
    check({tag, " busy"}, int'(busy), int'(eb));
  endtask

  // Drive inputs on the falling edge, let the rising edge sample them, then
  // settle 1 time unit before the caller looks at the outputs.
  task automatic apply(input logic s, input logic v, input int d);
    @(negedge clk);
    start    = s;
    in_valid = v;
    in_data  = 4'(d);
`ifdef ACC_CLEAR_EN
    clear    = 1'b0;
`endif
    @(posedge clk);
    #1;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks = 0;
    n_errors = 0;

    // idle with IN_VALID toggling, full window of +7, idle after DONE
    vecs[0]  = mk(1'b0, 1'b1,  5, 1'b0,  0, 1'b0);
    vecs[1]  = mk(1'b0, 1'b0,  0, 1'b0,  0, 1'b0);
    vecs[2]  = mk(1'b0, 1'b1, -8, 1'b0,  0, 1'b0);
    vecs[3]  = mk(1'b1, 1'b0,  0, 1'b0,  0, 1'b1);
    for (int i = 4; i <= 10; i++) vecs[i] = mk(1'b0, 1'b1, 7, 1'b0, 0, 1'b1);
    vecs[11] = mk(1'b0, 1'b1,  7, 1'b1, 56, 1'b1);
    vecs[12] = mk(1'b0, 1'b0,  0, 1'b0, 56, 1'b0);
    vecs[13] = mk(1'b0, 1'b1,  3, 1'b0, 56, 1'b0);
    // window 1,2,3 then stray START, then 1..5: total 21
    vecs[14] = mk(1'b1, 1'b0,  0, 1'b0, 56, 1'b1);
    vecs[15] = mk(1'b0, 1'b1,  1, 1'b0, 56, 1'b1);
    vecs[16] = mk(1'b0, 1'b1,  2, 1'b0, 56, 1'b1);
    vecs[17] = mk(1'b0, 1'b1,  3, 1'b0, 56, 1'b1);
    vecs[18] = mk(1'b1, 1'b0,  0, 1'b0, 56, 1'b1);
    vecs[19] = mk(1'b0, 1'b1,  1, 1'b0, 56, 1'b1);
    vecs[20] = mk(1'b0, 1'b1,  2, 1'b0, 56, 1'b1);
    vecs[21] = mk(1'b0, 1'b1,  3, 1'b0, 56, 1'b1);
    vecs[22] = mk(1'b0, 1'b1,  4, 1'b0, 56, 1'b1);
    vecs[23] = mk(1'b0, 1'b1,  5, 1'b1, 21, 1'b1);
    // START during DONE is ignored, so the following sample is too
    vecs[24] = mk(1'b1, 1'b0,  0, 1'b0, 21, 1'b0);
    vecs[25] = mk(1'b0, 1'b1,  7, 1'b0, 21, 1'b0);

    rst_n    = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
`ifdef ACC_CLEAR_EN
    clear    = 1'b0;
`endif
    repeat (2) @(negedge clk);
    check_outs("reset", 1'b0, 0, 1'b0);
    rst_n = 1'b1;

    // ---- table-driven vectors ----
    for (int i = 0; i < NVEC; i++) begin
      apply(vecs[i].start, vecs[i].in_valid, vecs[i].in_data);
      check_outs($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_data,
                 vecs[i].exp_busy);
    end

    // ---- 8 x -8 with 0..3-cycle gaps: total -64, BUSY high throughout ----
    apply(1'b1, 1'b0, 0);
    check_outs("gap start", 1'b0, 21, 1'b1);
    for (int i = 0; i < 8; i++) begin
      for (int g = 0; g < (i % 4); g++) begin
        apply(1'b0, 1'b0, 0);
        check_outs($sformatf("gap%0d idle%0d", i, g), 1'b0, 21, 1'b1);
      end
      apply(1'b0, 1'b1, -8);
      check_outs($sformatf("gap sample%0d", i), (i == 7), (i == 7) ? -64 : 21, 1'b1);
    end
    apply(1'b0, 1'b0, 0);
    check_outs("gap after", 1'b0, -64, 1'b0);

    // ---- reset after 5 samples: no strobe, then a clean 8 x +1 window ----
    apply(1'b1, 1'b0, 0);
    for (int i = 0; i < 5; i++) begin
      apply(1'b0, 1'b1, 1);
      check_outs($sformatf("abort sample%0d", i), 1'b0, -64, 1'b1);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_outs("async reset", 1'b0, 0, 1'b0);
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    apply(1'b0, 1'b1, 1);
    check_outs("post reset idle", 1'b0, 0, 1'b0);
    apply(1'b1, 1'b0, 0);
    for (int i = 0; i < 8; i++) begin
      apply(1'b0, 1'b1, 1);
      check_outs($sformatf("ones sample%0d", i), (i == 7), (i == 7) ? 8 : 0, 1'b1);
    end
    apply(1'b0, 1'b0, 0);
    check_outs("ones after", 1'b0, 8, 1'b0);

`ifdef ACC_CLEAR_EN
    // ---- CLEAR after 4 x +3 with IN_VALID high: abort, OUT_DATA kept ----
    apply(1'b1, 1'b0, 0);
    for (int i = 0; i < 4; i++) apply(1'b0, 1'b1, 3);
    @(negedge clk);
    clear    = 1'b1;
    in_valid = 1'b1;
    in_data  = 4'(3);
    @(posedge clk);
    #1;
    check_outs("clear abort", 1'b0, 8, 1'b0);
    for (int i = 0; i < 6; i++) begin
      apply(1'b0, 1'b1, 3);
      check_outs($sformatf("clear idle%0d", i), 1'b0, 8, 1'b0);
    end
    @(negedge clk);
    clear = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    check_outs("clear beats start", 1'b0, 8, 1'b0);
    apply(1'b0, 1'b0, 0);
    check_outs("clear final", 1'b0, 8, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_sample_accumulator

// File: doc/sample_accumulator.md
# sample_accumulator

- Windowed accumulator that sums exactly N = SAMPLES*OSF signed input samples and presents the total as one registered result with a single-cycle valid strobe.
- Sits directly upstream of `Suma`: two instances (e.g. I and Q, or two partial windows) feed `Suma.Input1`/`Input2`.
- Output width equals the `Suma` input width, so no truncation or extension is needed between stages.

## Interface
Parameters:
- SAMPLES, 128, samples per symbol window
- OSF, 8, oversampling factor; N = SAMPLES*OSF samples per window
- SIZE, 11, sample MSB index; samples are SIZE+1 bits, two's complement

Ports:
- CLK  in  1  rising-edge clock
- RST_N  in  1  asynchronous active-low reset
- START  in  1  begin a new window (honoured only in IDLE)
- IN_VALID  in  1  IN_DATA valid this cycle
- IN_DATA  in  SIZE+1  signed sample
- OUT_VALID  out  1  one-cycle strobe; OUT_DATA holds a new total
- OUT_DATA  out  $clog2(N)+SIZE+1  signed window total
- BUSY  out  1  high in ACC and DONE

## Operation
- Reset: one clock (CLK) and one asynchronous active-low reset (RST_N). Assertion of RST_N immediately forces: state IDLE, accumulator 0, counter 0, OUT_VALID 0, OUT_DATA 0, BUSY 0.
- FSM states:
  - IDLE: START=1 → ACC. Accumulator and counter clear on that edge.
  - ACC: each IN_VALID=1 cycle adds sign-extended IN_DATA and increments the counter. When the sample with counter = N-1 is accepted → DONE.
  - DONE: OUT_DATA ← final sum, OUT_VALID=1 for exactly this cycle → IDLE.
- Inputs ignored outside their state:
  - IN_VALID in IDLE/DONE is ignored; no sample is consumed.
  - START in ACC/DONE is ignored; no restart or abort.
- Arithmetic: accumulator is $clog2(N)+SIZE+1 bits signed, which holds N·(−2^SIZE) exactly. Overflow is therefore impossible; no saturation logic.
- Counter: $clog2(N) bits (minimum 1), wraps to 0 on the final sample.
- OUT_DATA holds its last value until the next DONE. It is never cleared except by reset.
- Reset mid-window discards the partial sum; OUT_VALID is not emitted.

## Timing
- START sampled at edge k → ACC from cycle k+1. The first sample can be accepted at edge k+1.
- Last sample accepted at edge m → OUT_VALID=1 and OUT_DATA valid during cycle m+1; IDLE from cycle m+2.
- Minimum window: N+2 cycles from START to the next START acceptance, with IN_VALID held high.
- IN_VALID gaps stretch the window without limit; there is no timeout.
- BUSY rises the cycle after START is accepted and falls the cycle after OUT_VALID.
- All outputs are registered; there is no combinational input-to-output path.

## Configuration
- ACC_CLEAR_EN defined:
  - Adds input port CLEAR (1 bit).
  - CLEAR=1 in any state → IDLE next edge, accumulator and counter to 0, OUT_VALID forced 0, OUT_DATA unchanged.
  - CLEAR takes priority over START and IN_VALID in the same cycle.
- ACC_CLEAR_EN undefined: port absent; windows can be aborted only by RST_N.

## Structure
- Shared package `acc_pkg`:
  - state enum {IDLE, ACC, DONE}
  - width constant functions: sample width SIZE+1, sum width $clog2(SAMPLES*OSF)+SIZE+1, counter width; reused by `Suma` wrappers.
- One natural sub-module: `acc_window_counter` (modulo-N counter with enable, clear and terminal-count output). The FSM and datapath stay in the top module.

## Test plan
All cases use SAMPLES=4, OSF=2, SIZE=3: N=8, 4-bit samples, 7-bit sum.
- Reset then idle, IN_VALID toggling with no START → OUT_VALID stays 0, OUT_DATA=0, BUSY=0.
- START, then 8 consecutive samples of +7 → OUT_VALID for one cycle, exactly 1 cycle after the 8th sample, OUT_DATA=56.
- START, 8 samples of −8 with IN_VALID gaps of 0–3 cycles → OUT_DATA=−64 (7'b1000000), no overflow; BUSY high throughout.
- Second START pulsed mid-window after 3 samples, then remaining samples 1..5 → START ignored; OUT_DATA equals sum of all 8 samples.
- RST_N asserted after 5 samples, released, new window of 8×(+1) → no strobe from the aborted window; OUT_DATA=8.
- With ACC_CLEAR_EN: CLEAR after 4 samples of +3 while IN_VALID=1 → IDLE next cycle, no OUT_VALID, OUT_DATA keeps its previous value.
